// File: rtl/pool_stage_sequencer.sv
// Five-stage enable sequencer for the second pooling layer: holds Ti1..Ti5 for their
// programmed latencies, repeats per tile, and pulses done once the job completes.
module pool_stage_sequencer #(
  parameter int unsigned LAT1      = 17,
  parameter int unsigned LAT2      = 14,
  parameter int unsigned LAT3      = 0,
  parameter int unsigned LAT4      = 16,
  parameter int unsigned LAT5      = 238,
  parameter int unsigned CNT_W     = 13,
  parameter int unsigned NUM_TILES = 1,
  parameter int unsigned TILE_W    = 8
) (
  input  logic              S_AXIS_ACLK,
  input  logic              S_AXIS_ARESET,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              stall,
  input  logic              abort,
  output logic [4:0]        stage_en,
  output logic [2:0]        stage_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] k);
    logic [CNT_W-1:0] r;
    case (k)
      3'd1:    r = CNT_W'(LAT1);
      3'd2:    r = CNT_W'(LAT2);
      3'd3:    r = CNT_W'(LAT3);
      3'd4:    r = CNT_W'(LAT4);
      3'd5:    r = CNT_W'(LAT5);
      default: r = {CNT_W{1'b0}};
    endcase
    return r;
  endfunction

  // Lowest-numbered stage above k with a nonzero latency; 0 when none remains.
  function automatic logic [2:0] next_nz(input logic [2:0] k);
    logic [2:0] r;
    r = 3'd0;
    for (int j = 5; j >= 1; j--) begin
      r = ((3'(j) > k) && (lat_of(3'(j)) != {CNT_W{1'b0}})) ? 3'(j) : r;
    end
    return r;
  endfunction

  function automatic logic [4:0] stage_onehot(input logic [2:0] k);
    logic [4:0] r;
    case (k)
      3'd1:    r = 5'b00001;
      3'd2:    r = 5'b00010;
      3'd3:    r = 5'b00100;
      3'd4:    r = 5'b01000;
      3'd5:    r = 5'b10000;
      default: r = 5'b00000;
    endcase
    return r;
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          stage_r, stage_s;
  logic [TILE_W-1:0]   tile_r, tile_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [2:0]          first_stage_s;
  logic [2:0]          next_stage_s;
  logic                last_cycle_s;

  // Next-state logic: abort first, then stage completion, then stall at the boundary.
  always_comb begin
    state_s       = state_r;
    stage_s       = stage_r;
    tile_s        = tile_r;
    cnt_s         = cnt_r;
    first_stage_s = next_nz(3'd0);
    next_stage_s  = next_nz(stage_r);
    last_cycle_s  = (cnt_r == (lat_of(stage_r) - CNT_W'(1)));
    case (state_r)
      IDLE: begin
        if (start_valid && !abort) begin
          tile_s = {TILE_W{1'b0}};
          cnt_s  = {CNT_W{1'b0}};
          if (first_stage_s != 3'd0) begin
            state_s = RUN;
            stage_s = first_stage_s;
          end else begin
            state_s = DONE;
            stage_s = 3'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          stage_s = 3'd0;
          tile_s  = {TILE_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
        end else if (last_cycle_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (next_stage_s != 3'd0) begin
            stage_s = next_stage_s;
            state_s = stall ? HOLD : RUN;
          end else if (tile_r == LAST_TILE) begin
            // stall has no say over the final transition into DONE
            state_s = DONE;
            stage_s = 3'd0;
          end else begin
            tile_s  = tile_r + TILE_W'(1);
            stage_s = first_stage_s;
            state_s = stall ? HOLD : RUN;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      HOLD: begin
        if (abort) begin
          state_s = IDLE;
          stage_s = 3'd0;
          tile_s  = {TILE_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
        end else if (!stall) begin
          state_s = RUN;
        end else begin
          state_s = HOLD;
        end
      end
      DONE: begin
        state_s = IDLE;
        stage_s = 3'd0;
        tile_s  = {TILE_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
        stage_s = 3'd0;
        tile_s  = {TILE_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers and registered outputs derived from the next state.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_r     <= IDLE;
      stage_r     <= 3'd0;
      tile_r      <= {TILE_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      stage_en    <= 5'b00000;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      state_r     <= state_s;
      stage_r     <= stage_s;
      tile_r      <= tile_s;
      cnt_r       <= cnt_s;
      stage_en    <= (state_s == RUN) ? stage_onehot(stage_s) : 5'b00000;
      busy        <= (state_s != IDLE);
      done        <= (state_s == DONE);
      start_ready <= (state_s == IDLE);
    end
  end

  assign stage_idx = stage_r;
  assign tile_idx  = tile_r;
  assign cycle_cnt = cnt_r;

endmodule

// File: tb/tb_pool_stage_sequencer.sv
// Directed, table-driven bench for pool_stage_sequencer (default DUT plus a 3-tile instance).
module tb_pool_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic stall = 1'b0;
  logic abort = 1'b0;

  logic        ready1, busy1, done1, ready3, busy3, done3;
  logic [4:0]  en1, en3;
  logic [2:0]  idx1, idx3;
  logic [7:0]  tile1, tile3;
  logic [12:0] cnt1, cnt3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         tid;
    int         rel;
    logic [4:0] en;
    int         idx;
    int         tile;   // -1 = not checked
    int         cnt;
    logic       busy;
    logic       ready;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pool_stage_sequencer dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start_valid(start1), .start_ready(ready1),
    .stall(stall), .abort(abort), .stage_en(en1), .stage_idx(idx1), .tile_idx(tile1),
    .cycle_cnt(cnt1), .busy(busy1), .done(done1)
  );

  pool_stage_sequencer #(.NUM_TILES(3)) dut3 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start_valid(start3), .start_ready(ready3),
    .stall(stall), .abort(abort), .stage_en(en3), .stage_idx(idx3), .tile_idx(tile3),
    .cycle_cnt(cnt3), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int tid, input int rel, input logic [4:0] en, input int idx,
                              input int tile, input int cnt, input logic busy, input logic ready,
                              input logic done);
    vecs.push_back('{tid, rel, en, idx, tile, cnt, busy, ready, done});
  endfunction

  // Start a job in the current cycle T, then walk rel = 1..last_rel comparing table rows.
  task automatic run_job(input int tid, input int last_rel, input bit on3,
                         input int s_lo1, input int s_hi1, input int s_lo2, input int s_hi2,
                         input int ab_rel, input int exp_dones);
    int dones;
    int saw3;
    int o_en, o_idx, o_tile, o_cnt, o_busy, o_ready, o_done;
    dones = 0;
    saw3 = 0;
    if (on3) start3 = 1'b1;
    else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    for (int rel = 1; rel <= last_rel; rel++) begin
      stall = ((rel >= s_lo1) && (rel <= s_hi1)) || ((rel >= s_lo2) && (rel <= s_hi2));
      abort = (rel == ab_rel);
      o_en    = on3 ? int'(en3)    : int'(en1);
      o_idx   = on3 ? int'(idx3)   : int'(idx1);
      o_tile  = on3 ? int'(tile3)  : int'(tile1);
      o_cnt   = on3 ? int'(cnt3)   : int'(cnt1);
      o_busy  = on3 ? int'(busy3)  : int'(busy1);
      o_ready = on3 ? int'(ready3) : int'(ready1);
      o_done  = on3 ? int'(done3)  : int'(done1);
      if (o_done != 0) dones++;
      if (o_en[2]) saw3 = 1;
      foreach (vecs[i]) begin
        if ((vecs[i].tid == tid) && (vecs[i].rel == rel)) begin
          check($sformatf("t%0d_r%0d_en", tid, rel), o_en, int'(vecs[i].en));
          check($sformatf("t%0d_r%0d_idx", tid, rel), o_idx, vecs[i].idx);
          if (vecs[i].tile >= 0) check($sformatf("t%0d_r%0d_tile", tid, rel), o_tile, vecs[i].tile);
          check($sformatf("t%0d_r%0d_cnt", tid, rel), o_cnt, vecs[i].cnt);
          check($sformatf("t%0d_r%0d_busy", tid, rel), o_busy, int'(vecs[i].busy));
          check($sformatf("t%0d_r%0d_ready", tid, rel), o_ready, int'(vecs[i].ready));
          check($sformatf("t%0d_r%0d_done", tid, rel), o_done, int'(vecs[i].done));
        end
      end
      tick();
    end
    stall = 1'b0;
    abort = 1'b0;
    check($sformatf("t%0d_done_count", tid), dones, exp_dones);
    check($sformatf("t%0d_stage3_never", tid), saw3, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, int'(en1), 0);
    check({tag, "_idx"}, int'(idx1), 0);
    check({tag, "_tile"}, int'(tile1), 0);
    check({tag, "_cnt"}, int'(cnt1), 0);
    check({tag, "_busy"}, int'(busy1), 0);
    check({tag, "_done"}, int'(done1), 0);
    check({tag, "_ready"}, int'(ready1), 1);
  endtask

  initial begin
    int accepts;
    int dn;

    // test 1: default single-tile sequence
    add(1,   1, 5'b00001, 1, 0,   0, 1'b1, 1'b0, 1'b0);
    add(1,  17, 5'b00001, 1, 0,  16, 1'b1, 1'b0, 1'b0);
    add(1,  18, 5'b00010, 2, 0,   0, 1'b1, 1'b0, 1'b0);
    add(1,  31, 5'b00010, 2, 0,  13, 1'b1, 1'b0, 1'b0);
    add(1,  32, 5'b01000, 4, 0,   0, 1'b1, 1'b0, 1'b0);
    add(1,  47, 5'b01000, 4, 0,  15, 1'b1, 1'b0, 1'b0);
    add(1,  48, 5'b10000, 5, 0,   0, 1'b1, 1'b0, 1'b0);
    add(1, 285, 5'b10000, 5, 0, 237, 1'b1, 1'b0, 1'b0);
    add(1, 286, 5'b00000, 0, 0,   0, 1'b1, 1'b0, 1'b1);
    add(1, 287, 5'b00000, 0, 0,   0, 1'b0, 1'b1, 1'b0);
    // test 2: stall over 5..10 (no effect) and over 31..35 (five HOLD cycles)
    add(2,  11, 5'b00001, 1, 0,  10, 1'b1, 1'b0, 1'b0);
    add(2,  31, 5'b00010, 2, 0,  13, 1'b1, 1'b0, 1'b0);
    add(2,  32, 5'b00000, 4, 0,   0, 1'b1, 1'b0, 1'b0);
    add(2,  36, 5'b00000, 4, 0,   0, 1'b1, 1'b0, 1'b0);
    add(2,  37, 5'b01000, 4, 0,   0, 1'b1, 1'b0, 1'b0);
    add(2,  52, 5'b01000, 4, 0,  15, 1'b1, 1'b0, 1'b0);
    add(2,  53, 5'b10000, 5, 0,   0, 1'b1, 1'b0, 1'b0);
    add(2, 290, 5'b10000, 5, 0, 237, 1'b1, 1'b0, 1'b0);
    add(2, 291, 5'b00000, 0, 0,   0, 1'b1, 1'b0, 1'b1);
    add(2, 292, 5'b00000, 0, 0,   0, 1'b0, 1'b1, 1'b0);
    // test 3: three tiles on dut3
    add(3,   1, 5'b00001, 1,  0,   0, 1'b1, 1'b0, 1'b0);
    add(3, 285, 5'b10000, 5,  0, 237, 1'b1, 1'b0, 1'b0);
    add(3, 286, 5'b00001, 1,  1,   0, 1'b1, 1'b0, 1'b0);
    add(3, 570, 5'b10000, 5,  1, 237, 1'b1, 1'b0, 1'b0);
    add(3, 571, 5'b00001, 1,  2,   0, 1'b1, 1'b0, 1'b0);
    add(3, 855, 5'b10000, 5,  2, 237, 1'b1, 1'b0, 1'b0);
    add(3, 856, 5'b00000, 0, -1,   0, 1'b1, 1'b0, 1'b1);
    add(3, 857, 5'b00000, 0,  0,   0, 1'b0, 1'b1, 1'b0);
    // test 4: abort in stage 5
    add(4, 100, 5'b10000, 5, 0, 52, 1'b1, 1'b0, 1'b0);
    add(4, 101, 5'b00000, 0, 0,  0, 1'b0, 1'b1, 1'b0);

    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_ready3", int'(ready3), 1);
    check("reset_busy3", int'(busy3), 0);
    rst = 1'b0;
    tick();

    run_job(1, 290, 1'b0, 0, -1, 0, -1, 0, 1);
    run_job(2, 295, 1'b0, 5, 10, 31, 35, 0, 1);
    run_job(3, 860, 1'b1, 0, -1, 0, -1, 0, 1);
    run_job(4, 300, 1'b0, 0, -1, 0, -1, 100, 0);
    run_job(1, 290, 1'b0, 0, -1, 0, -1, 0, 1);

    // start_valid held high: one accept per IDLE visit
    accepts = 0;
    dn = 0;
    start1 = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (ready1 && start1) accepts++;
      if (done1) dn++;
      if (c == 288) begin
        check("held_restart_en", int'(en1), 1);
        check("held_restart_cnt", int'(cnt1), 0);
      end
      tick();
    end
    check("held_accepts", accepts, 3);
    check("held_dones", dn, 2);
    start1 = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy1), 0);
    check("abort_ready", int'(ready1), 1);

    // start and abort together in IDLE: no accept
    start1 = 1'b1;
    abort = 1'b1;
    tick();
    start1 = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy1), 0);
    check("start_abort_ready", int'(ready1), 1);
    tick();
    check("start_abort_en", int'(en1), 0);

    // synchronous reset mid-job
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int r = 1; r < 60; r++) tick();
    check("pre_reset_en", int'(en1), 16);
    check("pre_reset_cnt", int'(cnt1), 12);
    rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    rst = 1'b0;
    tick();
    run_job(1, 290, 1'b0, 0, -1, 0, -1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
